// File: rtl/ks_16b.sv
// ks_16b: 16-bit Kogge-Stone adder with a registered 17-bit sum and valid.
// Define KS_16B_PIPE_EN to add a register stage after prefix level 2 (latency 2).
`default_nettype none

module ks_16b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  output logic        out_valid,
  output logic [16:0] out0
);

  function automatic logic [15:0] ks_g(input logic [15:0] g_in, input logic [15:0] p_in,
                                       input int span);
    logic [15:0] g_out;
    g_out = g_in;
    for (int i = 0; i < 16; i++) begin
      if (i >= span) g_out[i] = g_in[i] | (p_in[i] & g_in[i-span]);
    end
    return g_out;
  endfunction

  function automatic logic [15:0] ks_p(input logic [15:0] p_in, input int span);
    logic [15:0] p_out;
    p_out = p_in;
    for (int i = 0; i < 16; i++) begin
      if (i >= span) p_out[i] = p_in[i] & p_in[i-span];
    end
    return p_out;
  endfunction

  logic [15:0] g0, p0, g1, p1, g2, p2;
  logic [15:0] g2_s, p2_s, bit_p_s;
  logic        valid_s;
  logic [15:0] g3, p3, g4;
  logic [16:0] sum;

  assign g0 = in0 & in1;
  assign p0 = in0 ^ in1;
  assign g1 = ks_g(g0, p0, 1);
  assign p1 = ks_p(p0, 1);
  assign g2 = ks_g(g1, p1, 2);
  assign p2 = ks_p(p1, 2);

`ifdef KS_16B_PIPE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g2_s    <= '0;
      p2_s    <= '0;
      bit_p_s <= '0;
      valid_s <= 1'b0;
    end else begin
      g2_s    <= g2;
      p2_s    <= p2;
      bit_p_s <= p0;
      valid_s <= in_valid;
    end
  end
`else
  assign g2_s    = g2;
  assign p2_s    = p2;
  assign bit_p_s = p0;
  assign valid_s = in_valid;
`endif

  assign g3 = ks_g(g2_s, p2_s, 4);
  assign p3 = ks_p(p2_s, 4);
  // Level 4 only needs group generate; its propagate would be unused.
  assign g4 = ks_g(g3, p3, 8);

  assign sum = {g4[15], bit_p_s[15:1] ^ g4[14:0], bit_p_s[0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out0      <= 17'd0;
      out_valid <= 1'b0;
    end else begin
      out0      <= sum;
      out_valid <= valid_s;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ks_16b.sv
// tb_ks_16b: table-driven directed vectors plus a random stream for ks_16b.
`default_nettype none

module tb_ks_16b;

`ifdef KS_16B_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NTAB = 19;
  localparam int NRND = 300;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] exp_sum;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in0, in1;
  logic        out_valid;
  logic [16:0] out0;

  int checks = 0;
  int errors = 0;

  vec_t tab [NTAB];
  logic [15:0] ra [NRND];
  logic [15:0] rb [NRND];
  logic        rv [NRND];

  ks_16b dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in0      (in0),
    .in1      (in1),
    .out_valid(out_valid),
    .out0     (out0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%05h), expected %0d (0x%05h)", name, act, act, exp, exp);
    end
  endtask

  initial begin
    // {rst_n, in_valid, in0, in1, hand-computed sum}
    tab[0]  = '{1'b0, 1'b1, 16'd1234,  16'd4321,  17'd5555};
    tab[1]  = '{1'b0, 1'b1, 16'd1234,  16'd4321,  17'd5555};
    tab[2]  = '{1'b1, 1'b1, 16'd1234,  16'd4321,  17'd5555};
    tab[3]  = '{1'b1, 1'b1, 16'hFFFF,  16'h0001,  17'd65536};
    tab[4]  = '{1'b1, 1'b1, 16'd65535, 16'd65535, 17'd131070};
    tab[5]  = '{1'b1, 1'b0, 16'd0,     16'd0,     17'd0};
    tab[6]  = '{1'b1, 1'b1, 16'h5555,  16'hAAAA,  17'd65535};
    tab[7]  = '{1'b1, 1'b1, 16'h8000,  16'h8000,  17'd65536};
    tab[8]  = '{1'b1, 1'b1, 16'd12345, 16'd54321, 17'd66666};
    tab[9]  = '{1'b1, 1'b0, 16'd1,     16'd2,     17'd3};
    tab[10] = '{1'b1, 1'b1, 16'd40000, 16'd30000, 17'd70000};
    tab[11] = '{1'b0, 1'b1, 16'd100,   16'd200,   17'd300};
    tab[12] = '{1'b1, 1'b1, 16'd7,     16'd8,     17'd15};
    tab[13] = '{1'b1, 1'b1, 16'h1234,  16'h4321,  17'h05555};
    tab[14] = '{1'b1, 1'b0, 16'h00FF,  16'h0001,  17'h00100};
    tab[15] = '{1'b1, 1'b1, 16'h7FFF,  16'h0001,  17'h08000};
    tab[16] = '{1'b1, 1'b1, 16'h7FFF,  16'h0001,  17'h08000};
    tab[17] = '{1'b1, 1'b1, 16'd0,     16'd0,     17'd0};
    tab[18] = '{1'b1, 1'b0, 16'd0,     16'd0,     17'd0};

    rst_n = 1'b0; in_valid = 1'b0; in0 = '0; in1 = '0;

    for (int i = 0; i < NTAB; i++) begin
      logic        live;
      logic [16:0] e_sum;
      logic        e_val;
      rst_n    = tab[i].rst_n;
      in_valid = tab[i].valid;
      in0      = tab[i].a;
      in1      = tab[i].b;
      @(posedge clk);
      #1;
      // Output after edge i reflects edge i-LAT+1, unless reset hit any edge in between.
      live = 1'b1;
      for (int j = 0; j < LAT; j++) begin
        if (i - j < 0) live = 1'b0;
        else if (!tab[i-j].rst_n) live = 1'b0;
      end
      e_sum = live ? tab[i-LAT+1].exp_sum : 17'd0;
      e_val = live ? tab[i-LAT+1].valid   : 1'b0;
      check($sformatf("vec%0d out0", i), out0, e_sum);
      check($sformatf("vec%0d out_valid", i), {16'd0, out_valid}, {16'd0, e_val});
    end

    // Random back-to-back stream with no reset; reference is the plain 17-bit sum.
    rst_n = 1'b1;
    for (int k = 0; k < NRND; k++) begin
      ra[k] = 16'($urandom);
      rb[k] = 16'($urandom);
      rv[k] = 1'($urandom_range(0, 1));
      if (k % 50 == 0) begin
        ra[k] = 16'hFFFF;
        rb[k] = 16'($urandom_range(1, 65535));
      end
      in0      = ra[k];
      in1      = rb[k];
      in_valid = rv[k];
      @(posedge clk);
      #1;
      if (k >= LAT - 1) begin
        check($sformatf("rnd%0d out0", k), out0,
              {1'b0, ra[k-LAT+1]} + {1'b0, rb[k-LAT+1]});
        check($sformatf("rnd%0d out_valid", k), {16'd0, out_valid}, {16'd0, rv[k-LAT+1]});
      end
    end

    // Held operands must give a steady result.
    in0 = 16'hBEEF; in1 = 16'hCAFE; in_valid = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      @(posedge clk);
      #1;
      if (k >= LAT - 1) check($sformatf("hold%0d out0", k), out0, 17'h189ED);
    end

    // Reset asserted mid-stream clears outputs on the next edge.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst out0", out0, 17'd0);
    check("midrst out_valid", {16'd0, out_valid}, 17'd0);
    rst_n = 1'b1; in0 = 16'd1000; in1 = 16'd2000; in_valid = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      @(posedge clk);
      #1;
    end
    check("postrst out0", out0, 17'd3000);
    check("postrst out_valid", {16'd0, out_valid}, 17'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ks_16b.md
Name: ks_16b

Overview:
- 16-bit unsigned adder built on a Kogge-Stone parallel-prefix carry network.
- Produces a 17-bit sum that includes the carry-out.
- Serves as a benchmark and datapath arithmetic block.
- Operands are sampled into a registered output stage. Valid is tracked alongside the data, so it drops into clocked datapaths with a fixed latency.

Parameters:
- None. The width is fixed at 16; the prefix tree depth is fixed at 4 levels (spans 1, 2, 4, 8).

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  qualifies in0/in1 in the current cycle
- in0  input  16  operand A, unsigned
- in1  input  16  operand B, unsigned
- out_valid  output  1  out0 holds a result
- out0  output  17  sum; bit 16 is the carry-out

Behaviour:
- Interface: one clock (clk) and a synchronous, active-low reset (rst_n). Reset is sampled only on the rising edge of clk.
- Reset:
  - When rst_n=0 at a rising edge, out0<=17'd0 and out_valid<=0.
  - Any pipeline state also clears to 0.
  - Operands presented in the same cycle are discarded.
- Arithmetic: out0 = {1'b0,in0} + {1'b0,in1}, exact with no overflow. There is no carry-in.
- Prefix structure, required and must be explicit rather than inferred through "+":
  - Bit level: g[i]=in0[i]&in1[i], p[i]=in0[i]^in1[i].
  - Level k=1..4, span d=2^(k-1). For i>=d: G=G[i] | (P[i] & G[i-d]) and P=P[i] & P[i-d]. For i<d, the pair passes through unchanged.
  - After level 4, G[i] is the carry out of bits [i:0].
  - Sum: s[0]=p[0]; s[i]=p[i]^G[i-1] for i=1..15; s[16]=G[15].
- Timing:
  - Latency is 1 cycle. Operands and in_valid are sampled at rising edge N, and out0/out_valid update at edge N (visible after it).
  - Throughput is one addition per cycle, with no back-pressure.
- out0 updates every cycle with the current operands regardless of in_valid. out_valid is the registered copy of in_valid. Consumers qualify data with out_valid.
- Holding the inputs constant gives a stable out0.
- Boundaries:
  - All-ones operands: 65535+65535 gives 131070 with bit 16 set.
  - Full carry ripple: 0xFFFF+1 gives 0x10000. The carry must propagate through all 4 levels.
- Reset mid-stream: outputs read 0 the cycle after reset is asserted. The first result after deassertion is the operands sampled at the first edge with rst_n=1.

Optional Feature:
- Macro: KS_16B_PIPE_EN.
- When defined, a register stage is inserted after prefix level 2, covering the G/P vectors, p[], and valid. Latency becomes 2 cycles, throughput stays 1 per cycle, and the stage is cleared by reset.
- When undefined, the block is purely combinational between the operands and the output register, with latency 1.
- Arithmetic results are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in0=1234, in1=4321 -> out0=0, out_valid=0; after release, out0=5555 one cycle later (two with KS_16B_PIPE_EN).
- Carry chain: in0=0xFFFF, in1=0x0001, in_valid=1 -> out0=65536, out_valid=1.
- Maximum: in0=65535, in1=65535 -> out0=131070; in0=0, in1=0 -> out0=0.
- Alternating patterns: in0=0x5555, in1=0xAAAA -> out0=65535; in0=0x8000, in1=0x8000 -> out0=65536.
- Back-to-back stream: 12345+54321, 1+2, 40000+30000 on consecutive cycles -> 66666, 3, 70000 on consecutive cycles at fixed latency; in_valid toggling is mirrored by out_valid.
- Random regression: 1,000,000 random operand pairs -> every out0 equals the 17-bit reference sum; repeat with KS_16B_PIPE_EN defined.
